cr_inverse_transform: RTL and testbench

- Pipelined inverse of the skin-tone nonlinear chroma transform.
- Takes a luma value Y and a transformed chroma Cr'. Recovers the original Cr:
  Cr = (Cr' - meancr(Kh)) * Wcr(Y) / Wcr + meancr(Y) when Y <= K_l or Y >= K_h. Otherwise Cr = Cr'.
- Sits after the classifier when the debug or reconstruction path is enabled.
- Reuses the existing meancr block for meancr(Y).

---
 rtl/cr_inv_pkg.sv | 39 +++
 rtl/meancr.sv | 23 ++
 rtl/wcr_calc.sv | 23 ++
 rtl/cr_inverse_transform.sv | 100 ++++++++++
 tb/tb_cr_inverse_transform.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/cr_inv_pkg.sv
// Shared constants, types and helpers for the inverse skin-tone chroma transform.
// Chroma values are unsigned Q8.FRAC. Constant divisions use ceil reciprocals with DIV_FRAC bits,
// which is enough for them to match exact floor division over the clamped luma range.
package cr_inv_pkg;

  localparam int FRAC       = 8;
  localparam int CR_W       = 8 + FRAC;
  localparam int RECIP_FRAC = 16;
  localparam int DIV_FRAC   = 28;

  typedef logic [CR_W-1:0]        cr_t;
  typedef logic signed [CR_W:0]   crd_t;

  localparam logic [7:0] K_L   = 8'd125;
  localparam logic [7:0] K_H   = 8'd188;
  localparam logic [7:0] Y_MIN = 8'd16;
  localparam logic [7:0] Y_MAX = 8'd235;

  localparam cr_t MEANCR_KH      = cr_t'(154 << FRAC);
  localparam cr_t WCR            = cr_t'((3876 * (1 << FRAC) + 50) / 100);
  localparam cr_t WLCR           = cr_t'(20 << FRAC);
  localparam cr_t WHCR           = cr_t'(10 << FRAC);
  localparam cr_t MEANCR_LO_SPAN = cr_t'(10 << FRAC);
  localparam cr_t MEANCR_HI_SPAN = cr_t'(22 << FRAC);

  localparam logic [11:0] RECIP_WCR = 12'd1691;

  localparam int LO_SPAN = int'(K_L) - int'(Y_MIN);
  localparam int HI_SPAN = int'(Y_MAX) - int'(K_H);
  localparam logic [23:0] RECIP_LO = 24'(((1 << DIV_FRAC) + LO_SPAN - 1) / LO_SPAN);
  localparam logic [23:0] RECIP_HI = 24'(((1 << DIV_FRAC) + HI_SPAN - 1) / HI_SPAN);

  function automatic logic [7:0] clamp_y(input logic [7:0] y);
    if (y < Y_MIN)      return Y_MIN;
    else if (y > Y_MAX) return Y_MAX;
    else                return y;
  endfunction

endpackage

// File: rtl/meancr.sv
// Luma-dependent chroma cluster centre meancr(Y), Q8.FRAC; expects luma already clamped.
module meancr
  import cr_inv_pkg::*;
(
  input  logic [7:0] y,
  output cr_t        m
);

  logic [7:0]  lo_dy, hi_dy;
  logic [47:0] lo_prod, hi_prod;

  assign lo_dy   = K_L - y;
  assign hi_dy   = y - K_H;
  assign lo_prod = 48'(lo_dy) * 48'(MEANCR_LO_SPAN) * 48'(RECIP_LO);
  assign hi_prod = 48'(hi_dy) * 48'(MEANCR_HI_SPAN) * 48'(RECIP_HI);

  always_comb begin
    m = MEANCR_KH;
    if (y <= K_L)      m = MEANCR_KH + cr_t'(lo_prod >> DIV_FRAC);
    else if (y >= K_H) m = MEANCR_KH + cr_t'(hi_prod >> DIV_FRAC);
  end

endmodule

// File: rtl/wcr_calc.sv
// Cluster width Wcr(Y), Q8.FRAC, linearly tapered outside the pass-through band.
module wcr_calc
  import cr_inv_pkg::*;
(
  input  logic [7:0] y,
  output cr_t        w
);

  logic [7:0]  lo_dy, hi_dy;
  logic [47:0] lo_prod, hi_prod;

  assign lo_dy   = y - Y_MIN;
  assign hi_dy   = Y_MAX - y;
  assign lo_prod = 48'(lo_dy) * 48'(WCR - WLCR) * 48'(RECIP_LO);
  assign hi_prod = 48'(hi_dy) * 48'(WCR - WHCR) * 48'(RECIP_HI);

  always_comb begin
    w = WCR;
    if (y <= K_L)      w = WLCR + cr_t'(lo_prod >> DIV_FRAC);
    else if (y >= K_H) w = WHCR + cr_t'(hi_prod >> DIV_FRAC);
  end

endmodule

// File: rtl/cr_inverse_transform.sv
// Three-stage pipelined inverse of the nonlinear Cr transform with a global stall.
// Define CR_INV_ROUND_EN to round the final rescale half-up instead of truncating.
module cr_inverse_transform
  import cr_inv_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [7:0]      in_y,
  input  logic [CR_W-1:0] in_crp,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [CR_W-1:0] out_cr,
  output logic            out_bypass
);

  localparam int ACC_W = CR_W + 4;
  localparam int SHIFT = FRAC + RECIP_FRAC;

  logic                     advance;
  logic                     v1, v2, v3;
  logic [7:0]               yc, yc_in;
  logic                     byp1, byp2;
  crd_t                     d1;
  cr_t                      crp1, crp2, m2, m_yc, w_yc;
  logic signed [2*CR_W+1:0] p2;
  logic signed [47:0]       prod3, prod_rnd;
  logic signed [ACC_W-1:0]  q3, r3;
  cr_t                      sat3;

  // The whole pipeline freezes only when the last stage holds an unaccepted pixel.
  assign advance   = !v3 || out_ready;
  assign in_ready  = advance;
  assign out_valid = v3;
  assign yc_in     = clamp_y(in_y);

  meancr u_meancr (.y(yc), .m(m_yc));
  wcr_calc u_wcr_calc (.y(yc), .w(w_yc));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1   <= 1'b0;
      yc   <= '0;
      byp1 <= 1'b0;
      d1   <= '0;
      crp1 <= '0;
    end else if (advance) begin
      v1   <= in_valid;
      yc   <= yc_in;
      byp1 <= (yc_in > K_L) && (yc_in < K_H);
      d1   <= $signed({1'b0, in_crp}) - $signed({1'b0, MEANCR_KH});
      crp1 <= in_crp;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2   <= 1'b0;
      p2   <= '0;
      m2   <= '0;
      byp2 <= 1'b0;
      crp2 <= '0;
    end else if (advance) begin
      v2   <= v1;
      p2   <= d1 * $signed({1'b0, w_yc});
      m2   <= m_yc;
      byp2 <= byp1;
      crp2 <= crp1;
    end
  end

  // Divide by the nominal width via its Q0.16 reciprocal, re-centre, then clip to Q8.FRAC.
  always_comb begin
    prod3 = 48'(p2) * $signed({36'd0, RECIP_WCR});
`ifdef CR_INV_ROUND_EN
    prod_rnd = prod3 + (48'sd1 <<< (SHIFT - 1));
`else
    prod_rnd = prod3;
`endif
    q3 = ACC_W'(prod_rnd >>> SHIFT);
    r3 = q3 + $signed({4'd0, m2});
    if (r3[ACC_W-1])             sat3 = '0;
    else if (|r3[ACC_W-2:CR_W])  sat3 = '1;
    else                         sat3 = r3[CR_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v3         <= 1'b0;
      out_cr     <= '0;
      out_bypass <= 1'b0;
    end else if (advance) begin
      v3         <= v2;
      out_cr     <= byp2 ? crp2 : sat3;
      out_bypass <= byp2;
    end
  end

endmodule

// File: tb/tb_cr_inverse_transform.sv
// Self-checking bench: directed vector table, stall/reset sequences and a randomized scoreboard.
module tb_cr_inverse_transform;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_y;
  logic [15:0] in_crp;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_cr;
  logic        out_bypass;

  typedef struct {
    logic [7:0]  y;
    logic [15:0] crp;
    int          cr;
    bit          byp;
    int          tol;
  } tv_t;

  typedef struct {
    int cr;
    bit byp;
  } exp_t;

  int   total = 0;
  int   bad = 0;
  exp_t expq[$];
  bit   lastAccepted;
  bit   lastInReady;

  cr_inverse_transform dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_y      (in_y),
    .in_crp    (in_crp),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_cr    (out_cr),
    .out_bypass(out_bypass)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference: the inverse transform from its defining formulas, using exact integer division.
  function automatic void refModel(input int y, input int crp, output int cr, output bit byp);
    longint yc, w, m, prod, q, r;
    yc = (y < 16) ? 16 : ((y > 235) ? 235 : y);
    if (yc > 125 && yc < 188) begin
      cr  = crp;
      byp = 1'b1;
      return;
    end
    byp = 1'b0;
    if (yc <= 125) begin
      w = 20 * 256 + ((yc - 16) * (9923 - 20 * 256)) / (125 - 16);
      m = 154 * 256 + ((125 - yc) * (10 * 256)) / (125 - 16);
    end else begin
      w = 10 * 256 + ((235 - yc) * (9923 - 10 * 256)) / (235 - 188);
      m = 154 * 256 + ((yc - 188) * (22 * 256)) / (235 - 188);
    end
    prod = (longint'(crp) - 154 * 256) * w * 1691;
`ifdef CR_INV_ROUND_EN
    prod = prod + (64'sd1 <<< 23);
`endif
    q = prod >>> 24;
    r = q + m;
    if (r < 0) r = 0;
    if (r > 65535) r = 65535;
    cr = int'(r);
  endfunction

  task automatic checkOutput(input string name, input longint actual, input longint expected, input int tol);
    longint diff;
    total++;
    diff = actual - expected;
    if (diff < 0) diff = -diff;
    if (diff > tol) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d (tol %0d)", name, actual, expected, tol);
    end
  endtask

  // One clock of streaming traffic; outputs and acceptance are judged just after the falling edge.
  task automatic applyStimulus(input bit iv, input logic [7:0] y, input logic [15:0] crp, input bit ordy);
    exp_t e;
    int   cr;
    bit   byp;
    @(negedge clk);
    in_valid  = iv;
    in_y      = y;
    in_crp    = crp;
    out_ready = ordy;
    #1;
    lastInReady  = in_ready;
    lastAccepted = in_valid && in_ready;
    if (out_valid && out_ready) begin
      if (expq.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_output: got cr=%0d expected no output", out_cr);
      end else begin
        e = expq.pop_front();
        checkOutput("stream_cr", out_cr, e.cr, 0);
        checkOutput("stream_bypass", out_bypass, e.byp, 0);
      end
    end
    if (lastAccepted) begin
      refModel(y, crp, cr, byp);
      expq.push_back('{cr, byp});
    end
  endtask

  task automatic runOne(input tv_t tv, input int idx);
    int lat;
    @(negedge clk);
    in_valid  = 1'b1;
    in_y      = tv.y;
    in_crp    = tv.crp;
    out_ready = 1'b1;
    #1;
    checkOutput($sformatf("idle_in_ready_%0d", idx), in_ready, 1, 0);
    @(posedge clk);
    lat = 1;
    #1;
    in_valid = 1'b0;
    while (!out_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput($sformatf("latency_%0d", idx), lat, 3, 0);
    checkOutput($sformatf("out_valid_%0d", idx), out_valid, 1, 0);
    checkOutput($sformatf("out_cr_%0d", idx), out_cr, tv.cr, tv.tol);
    checkOutput($sformatf("out_bypass_%0d", idx), out_bypass, tv.byp, 0);
  endtask

  initial begin
    tv_t tbl[10];
    int  sent;
    int  cyc;
    logic [7:0] ys[10];

    // Y=0 lands at 21639 (84.53) with the quantised constants; the nominal 84.5 is a rounded figure.
    tbl[0] = '{8'd150, 16'h9A00, 'h9A00, 1'b1, 0};
    tbl[1] = '{8'd188, 16'hAA00, 'hAA00, 1'b0, 1};
    tbl[2] = '{8'd125, 16'hAA00, 'hAA00, 1'b0, 1};
    tbl[3] = '{8'd16,  16'hC0C3, 'hB800, 1'b0, 1};
    tbl[4] = '{8'd235, 16'h9A00, 'hB000, 1'b0, 1};
    tbl[5] = '{8'd255, 16'hFF00, 51727,  1'b0, 1};
    tbl[6] = '{8'd0,   16'h0000, 21639,  1'b0, 1};
    tbl[7] = '{8'd125, 16'h0000, 0,      1'b0, 0};
    tbl[8] = '{8'd188, 16'hFFFF, 65535,  1'b0, 0};
    tbl[9] = '{8'd140, 16'h1234, 'h1234, 1'b1, 0};

    in_valid  = 1'b0;
    in_y      = '0;
    in_crp    = '0;
    out_ready = 1'b1;
    rst_n     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_out_valid", out_valid, 0, 0);
    checkOutput("reset_out_cr", out_cr, 0, 0);
    checkOutput("reset_out_bypass", out_bypass, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("reset_in_ready", in_ready, 1, 0);

    $display("[TB] directed vectors");
    for (int i = 0; i < 10; i++) runOne(tbl[i], i);
    @(posedge clk);
    #1;
    checkOutput("drained_after_table", out_valid, 0, 0);

    $display("[TB] back-to-back stream with downstream stall");
    ys = '{8'd0, 8'd40, 8'd100, 8'd125, 8'd150, 8'd188, 8'd200, 8'd235, 8'd250, 8'd60};
    sent = 0;
    cyc  = 0;
    while ((sent < 10 || expq.size() != 0) && cyc < 60) begin
      applyStimulus(sent < 10, ys[sent % 10], 16'($urandom_range(0, 65535)), !(cyc >= 4 && cyc <= 7));
      if (cyc < 10) checkOutput($sformatf("stall_in_ready_c%0d", cyc), lastInReady, !(cyc >= 4 && cyc <= 7), 0);
      if (lastAccepted) sent++;
      cyc++;
    end
    checkOutput("stream_sent", sent, 10, 0);
    checkOutput("stream_pending", expq.size(), 0, 0);

    $display("[TB] reset with pixels in flight");
    applyStimulus(1'b1, 8'd200, 16'hB000, 1'b1);
    applyStimulus(1'b1, 8'd30,  16'h7000, 1'b1);
    applyStimulus(1'b1, 8'd220, 16'hC800, 1'b1);
    @(posedge clk);
    #2;
    checkOutput("pre_reset_out_valid", out_valid, 1, 0);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    checkOutput("midreset_out_valid", out_valid, 0, 0);
    checkOutput("midreset_out_cr", out_cr, 0, 0);
    expq.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("release_in_ready", in_ready, 1, 0);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 8'd0, 16'd0, 1'b1);
      checkOutput($sformatf("no_stale_%0d", i), out_valid, 0, 0);
    end

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, 8'($urandom_range(0, 255)),
                    16'($urandom_range(0, 65535)), $urandom_range(0, 3) != 0);
    end
    cyc = 0;
    while (expq.size() != 0 && cyc < 20) begin
      applyStimulus(1'b0, 8'd0, 16'd0, 1'b1);
      cyc++;
    end
    checkOutput("random_pending", expq.size(), 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
